// File: rtl/phy_regfile_ckpt_pkg.sv
// Shared sizing constants and types for the physical register file with
// valid-vector checkpoints.
package phy_regfile_ckpt_pkg;
  localparam int PHY_REG_NUM      = 64;
  localparam int ARCH_REG_NUM     = 32;
  localparam int DATA_WIDTH       = 32;
  localparam int CKPT_NUM         = 4;
  localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);
  localparam int REG_DATA_WIDTH   = DATA_WIDTH;
  localparam int CKPT_ID_WIDTH    = $clog2(CKPT_NUM);

  typedef logic [PHY_REG_NUM-1:0] phy_valid_vec_t;
endpackage

// File: rtl/phy_regfile_wb_mux.sv
// Priority select across writeback ports for one address: the lowest enabled
// port index whose id matches supplies the data.
import phy_regfile_ckpt_pkg::*;

module phy_regfile_wb_mux #(
  parameter int PRW        = PHY_REG_ID_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int WB_PORTS   = 2
) (
  input  logic [PRW-1:0]               i_addr,
  input  logic [WB_PORTS*PRW-1:0]      i_wb_id,
  input  logic [WB_PORTS*DATA_WIDTH-1:0] i_wb_data,
  input  logic [WB_PORTS-1:0]          i_wb_we,
  output logic                         o_hit,
  output logic [DATA_WIDTH-1:0]        o_data
);
  // Scan high to low so the lowest matching port is written last and wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (i_wb_we[p] && (i_wb_id[p*PRW +: PRW] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wb_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
endmodule

// File: rtl/phy_regfile_ckpt.sv
// Physical register file with combinational reads, optional writeback bypass,
// commit invalidation and live-tracked snapshots of the data-valid vector.
import phy_regfile_ckpt_pkg::*;

module phy_regfile_ckpt #(
  parameter int PHY_REG_NUM  = phy_regfile_ckpt_pkg::PHY_REG_NUM,
  parameter int ARCH_REG_NUM = phy_regfile_ckpt_pkg::ARCH_REG_NUM,
  parameter int DATA_WIDTH   = phy_regfile_ckpt_pkg::DATA_WIDTH,
  parameter int RD_PORTS     = 8,
  parameter int WB_PORTS     = 2,
  parameter int INV_PORTS    = 2,
  parameter int CKPT_NUM     = phy_regfile_ckpt_pkg::CKPT_NUM,
  parameter int BYPASS       = 1,
  parameter int PRW          = $clog2(PHY_REG_NUM),
  parameter int CW           = $clog2(CKPT_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RD_PORTS*PRW-1:0]        i_rd_id,
  output logic [RD_PORTS*DATA_WIDTH-1:0] o_rd_data,
  output logic [RD_PORTS-1:0]            o_rd_valid,
  input  logic [WB_PORTS*PRW-1:0]        i_wb_id,
  input  logic [WB_PORTS*DATA_WIDTH-1:0] i_wb_data,
  input  logic [WB_PORTS-1:0]            i_wb_we,
  input  logic [INV_PORTS*PRW-1:0]       i_inv_id,
  input  logic [INV_PORTS-1:0]           i_inv_en,
  input  logic                           i_ckpt_save,
  input  logic [CW-1:0]                  i_ckpt_save_id,
  input  logic                           i_ckpt_restore,
  input  logic [CW-1:0]                  i_ckpt_restore_id,
  input  logic [CKPT_NUM-1:0]            i_ckpt_release,
  output logic [CKPT_NUM-1:0]            o_ckpt_live
);
  logic [DATA_WIDTH-1:0]  r_data [PHY_REG_NUM];
  logic [PHY_REG_NUM-1:0] r_valid;
  logic [PHY_REG_NUM-1:0] r_snap [CKPT_NUM];
  logic [CKPT_NUM-1:0]    r_live;

  logic [PHY_REG_NUM-1:0] w_wb_hit;
  logic [DATA_WIDTH-1:0]  w_wb_pdata [PHY_REG_NUM];
  logic [PHY_REG_NUM-1:0] w_inv_hit;
  logic [PHY_REG_NUM-1:0] w_valid_next;

  always_comb begin
    w_inv_hit = '0;
    for (int q = 0; q < INV_PORTS; q++) begin
      if (i_inv_en[q]) w_inv_hit[i_inv_id[q*PRW +: PRW]] = 1'b1;
    end
  end

  // Restore outranks everything, but a same-cycle writeback must still land.
  always_comb begin
    if (i_ckpt_restore) w_valid_next = r_snap[i_ckpt_restore_id] | w_wb_hit;
    else                w_valid_next = (r_valid & ~w_inv_hit) | w_wb_hit;
  end

  for (genvar g = 0; g < PHY_REG_NUM; g++) begin : g_preg
    phy_regfile_wb_mux #(.PRW(PRW), .DATA_WIDTH(DATA_WIDTH), .WB_PORTS(WB_PORTS)) u_wdec (
      .i_addr    (PRW'(g)),
      .i_wb_id   (i_wb_id),
      .i_wb_data (i_wb_data),
      .i_wb_we   (i_wb_we),
      .o_hit     (w_wb_hit[g]),
      .o_data    (w_wb_pdata[g])
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data[g]  <= '0;
        r_valid[g] <= (g >= 1) && (g < ARCH_REG_NUM);
      end else begin
        if (w_wb_hit[g]) r_data[g] <= w_wb_pdata[g];
        r_valid[g] <= w_valid_next[g];
      end
    end
  end

  // Live slots absorb every writeback so a later restore keeps completed results.
  for (genvar s = 0; s < CKPT_NUM; s++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        r_snap[s] <= '0;
        r_live[s] <= 1'b0;
      end else if (i_ckpt_save && (i_ckpt_save_id == CW'(s))) begin
        r_snap[s] <= w_valid_next;
        r_live[s] <= 1'b1;
      end else begin
        if (r_live[s])         r_snap[s] <= r_snap[s] | w_wb_hit;
        if (i_ckpt_release[s]) r_live[s] <= 1'b0;
      end
    end
  end

  assign o_ckpt_live = r_live;

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
    logic                  w_byp_hit;
    logic [DATA_WIDTH-1:0] w_byp_data;
    logic [PRW-1:0]        w_addr;

    assign w_addr = i_rd_id[r*PRW +: PRW];

    phy_regfile_wb_mux #(.PRW(PRW), .DATA_WIDTH(DATA_WIDTH), .WB_PORTS(WB_PORTS)) u_byp (
      .i_addr    (w_addr),
      .i_wb_id   (i_wb_id),
      .i_wb_data (i_wb_data),
      .i_wb_we   (i_wb_we),
      .o_hit     (w_byp_hit),
      .o_data    (w_byp_data)
    );

    always_comb begin
      if ((BYPASS != 0) && w_byp_hit) begin
        o_rd_data[r*DATA_WIDTH +: DATA_WIDTH] = w_byp_data;
        o_rd_valid[r]                         = 1'b1;
      end else begin
        o_rd_data[r*DATA_WIDTH +: DATA_WIDTH] = r_data[w_addr];
        o_rd_valid[r]                         = r_valid[w_addr];
      end
    end
  end

  a_restore_live: assert property (@(posedge clk) disable iff (rst)
    i_ckpt_restore |-> r_live[i_ckpt_restore_id]);
endmodule

// File: tb/tb_phy_regfile_ckpt.sv
// Directed bench for phy_regfile_ckpt: one bypassing and one non-bypassing
// instance share the same stimulus.
module tb_phy_regfile_ckpt;
  localparam int PRW = 6;
  localparam int DW  = 32;
  localparam int RD  = 8;
  localparam int WB  = 2;
  localparam int INV = 2;
  localparam int CK  = 4;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [RD*PRW-1:0]  rd_id;
  logic [WB*PRW-1:0]  wb_id;
  logic [WB*DW-1:0]   wb_data;
  logic [WB-1:0]      wb_we;
  logic [INV*PRW-1:0] inv_id;
  logic [INV-1:0]     inv_en;
  logic               ckpt_save;
  logic [CW-1:0]      ckpt_save_id;
  logic               ckpt_restore;
  logic [CW-1:0]      ckpt_restore_id;
  logic [CK-1:0]      ckpt_release;

  logic [RD*DW-1:0] rd_data_b, rd_data_n;
  logic [RD-1:0]    rd_valid_b, rd_valid_n;
  logic [CK-1:0]    live_b, live_n;

  int n_vec = 0;
  int n_err = 0;

  phy_regfile_ckpt #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .i_rd_id(rd_id), .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b),
    .i_wb_id(wb_id), .i_wb_data(wb_data), .i_wb_we(wb_we), .i_inv_id(inv_id), .i_inv_en(inv_en),
    .i_ckpt_save(ckpt_save), .i_ckpt_save_id(ckpt_save_id), .i_ckpt_restore(ckpt_restore),
    .i_ckpt_restore_id(ckpt_restore_id), .i_ckpt_release(ckpt_release), .o_ckpt_live(live_b)
  );

  phy_regfile_ckpt #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .i_rd_id(rd_id), .o_rd_data(rd_data_n), .o_rd_valid(rd_valid_n),
    .i_wb_id(wb_id), .i_wb_data(wb_data), .i_wb_we(wb_we), .i_inv_id(inv_id), .i_inv_en(inv_en),
    .i_ckpt_save(ckpt_save), .i_ckpt_save_id(ckpt_save_id), .i_ckpt_restore(ckpt_restore),
    .i_ckpt_restore_id(ckpt_restore_id), .i_ckpt_release(ckpt_release), .o_ckpt_live(live_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_we        = '0;
    inv_en       = '0;
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
    ckpt_release = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_rd(input int p, input logic [PRW-1:0] id);
    rd_id[p*PRW +: PRW] = id;
  endtask

  task automatic set_wb(input int p, input logic [PRW-1:0] id, input logic [DW-1:0] d);
    wb_id[p*PRW +: PRW] = id;
    wb_data[p*DW +: DW] = d;
    wb_we[p]            = 1'b1;
  endtask

  task automatic set_inv(input int p, input logic [PRW-1:0] id);
    inv_id[p*PRW +: PRW] = id;
    inv_en[p]            = 1'b1;
  endtask

  task automatic save(input logic [CW-1:0] id);
    ckpt_save    = 1'b1;
    ckpt_save_id = id;
  endtask

  task automatic restore(input logic [CW-1:0] id);
    ckpt_restore    = 1'b1;
    ckpt_restore_id = id;
  endtask

  function automatic logic [DW-1:0] dat_b(input int p);
    return rd_data_b[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] dat_n(input int p);
    return rd_data_n[p*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1;
    rd_id = '0; wb_id = '0; wb_data = '0; inv_id = '0;
    ckpt_save_id = '0; ckpt_restore_id = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    set_rd(0, 6'd0); set_rd(1, 6'd5); set_rd(2, 6'd40);
    #1;
    chk("t1_p0_valid",  32'(rd_valid_b[0]), 32'd0);
    chk("t1_p5_valid",  32'(rd_valid_b[1]), 32'd1);
    chk("t1_p40_valid", 32'(rd_valid_b[2]), 32'd0);
    chk("t1_p5_data",   dat_b(1), 32'h0);
    chk("t1_p40_data",  dat_b(2), 32'h0);
    chk("t1_live",      32'(live_b), 32'h0);

    // Same-cycle bypass vs array-only read
    set_wb(0, 6'd40, 32'hDEAD_BEEF); set_rd(0, 6'd40);
    #1;
    chk("t2_byp_data",   dat_b(0), 32'hDEAD_BEEF);
    chk("t2_byp_valid",  32'(rd_valid_b[0]), 32'd1);
    chk("t2_nb_data",    dat_n(0), 32'h0);
    chk("t2_nb_valid",   32'(rd_valid_n[0]), 32'd0);
    tick(); #1;
    chk("t2_nb_data_n",  dat_n(0), 32'hDEAD_BEEF);
    chk("t2_nb_valid_n", 32'(rd_valid_n[0]), 32'd1);

    // Write beats invalidate; port 0 beats port 1
    set_wb(0, 6'd33, 32'h11); set_wb(1, 6'd33, 32'h22); set_inv(0, 6'd33); set_rd(1, 6'd33);
    #1;
    chk("t3_byp_prio",  dat_b(1), 32'h11);
    tick(); #1;
    chk("t3_data",      dat_n(1), 32'h11);
    chk("t3_valid",     32'(rd_valid_n[1]), 32'd1);
    set_inv(1, 6'd33);
    tick(); #1;
    chk("t3_inv_valid", 32'(rd_valid_n[1]), 32'd0);
    chk("t3_inv_data",  dat_n(1), 32'h11);

    // Checkpoint tracks a later writeback
    set_rd(2, 6'd7); set_inv(0, 6'd7);
    tick(); #1;
    chk("t4_inv_valid", 32'(rd_valid_b[2]), 32'd0);
    save(2'd2);
    tick(); #1;
    chk("t4_live_save", 32'(live_b), 32'b0100);
    set_wb(0, 6'd7, 32'h5);
    tick();
    set_inv(0, 6'd7);
    tick(); #1;
    chk("t4_reinv_valid", 32'(rd_valid_b[2]), 32'd0);
    restore(2'd2);
    tick(); #1;
    chk("t4_rest_valid", 32'(rd_valid_b[2]), 32'd1);
    chk("t4_rest_data",  dat_b(2), 32'h5);
    chk("t4_p40_valid",  32'(rd_valid_b[0]), 32'd1);
    chk("t4_p33_valid",  32'(rd_valid_b[1]), 32'd0);
    chk("t4_live_keep",  32'(live_b), 32'b0100);

    // Save wins over release; restore keeps a same-cycle writeback
    save(2'd1); ckpt_release = 4'b0010;
    tick(); #1;
    chk("t5_live_save_rel", 32'(live_b), 32'b0110);
    restore(2'd1); set_wb(0, 6'd50, 32'h50); set_rd(3, 6'd50);
    tick(); #1;
    chk("t5_p50_valid", 32'(rd_valid_n[3]), 32'd1);
    chk("t5_p50_data",  dat_n(3), 32'h50);
    ckpt_release = 4'b0100;
    tick(); #1;
    chk("t5_live_rel",  32'(live_b), 32'b0010);

    // Reset in the middle of activity
    save(2'd0);
    tick();
    save(2'd3);
    tick(); #1;
    chk("t6_live_pre",  32'(live_b), 32'b1011);
    chk("t6_p40_pre",   32'(rd_valid_b[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rd(1, 6'd5); set_rd(2, 6'd0);
    #1;
    chk("t6_p40_valid", 32'(rd_valid_b[0]), 32'd0);
    chk("t6_p40_data",  dat_b(0), 32'h0);
    chk("t6_p5_valid",  32'(rd_valid_b[1]), 32'd1);
    chk("t6_p0_valid",  32'(rd_valid_b[2]), 32'd0);
    chk("t6_p50_data",  dat_b(3), 32'h0);
    chk("t6_live",      32'(live_b), 32'h0);
    chk("t6_live_nb",   32'(live_n), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
